sha256_w_schedule: RTL and testbench

- Message-schedule expander that produces the W-word stream consumed by the SHA-256 compression round engine.
- Accepts one padded 512-bit message block on a start pulse.
- Expands it to the full 64-word schedule, W0..W63, one word per cycle.
- Presents the result as a packed vector with a completion flag that feeds the round engine's w_vector and enable inputs.

---
 rtl/sha256_w_schedule_if.sv | 23 ++
 rtl/sha256_w_schedule.sv | 102 ++++++++++
 tb/tb_sha256_w_schedule.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sha256_w_schedule_if.sv
// rtl/sha256_w_schedule_if.sv - message-block request and W-schedule result bundle
interface sha256_w_schedule_if #(
    parameter int WK_LENGTH = 64
);
    localparam int IW = $clog2(WK_LENGTH);

    logic                    start;
    logic [511:0]            msg_block;
    logic [32*WK_LENGTH-1:0] w_vector;
    logic [IW-1:0]           w_index;
    logic                    busy;
    logic                    w_complete;

    modport master (
        output start, msg_block,
        input  w_vector, w_index, busy, w_complete
    );

    modport slave (
        input  start, msg_block,
        output w_vector, w_index, busy, w_complete
    );
endinterface

// File: rtl/sha256_w_schedule.sv
// rtl/sha256_w_schedule.sv - SHA-256 message schedule expander, one W word per cycle
module sha256_w_schedule #(
    parameter int WK_LENGTH = 64
) (
    input  logic                clock,
    input  logic                reset,
    sha256_w_schedule_if.slave  bus
);
    localparam int IW = $clog2(WK_LENGTH);
    localparam int VW = 32 * WK_LENGTH;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t           state;
    logic [VW-1:0]    w_vector;
    logic [IW-1:0]    w_index;
    logic             busy;
    logic             w_complete;

    logic [VW-1:0]    load_vector;
    logic [IW-1:0]    idx_m2;
    logic [IW-1:0]    idx_m7;
    logic [IW-1:0]    idx_m15;
    logic [IW-1:0]    idx_m16;
    logic [31:0]      w_m2;
    logic [31:0]      w_m7;
    logic [31:0]      w_m15;
    logic [31:0]      w_m16;
    logic [31:0]      new_word;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Reorder the big-endian block so W0 lands in the lowest word; upper words clear
    always_comb begin
        load_vector = '0;
        for (int i = 0; i < 16; i++) begin
            load_vector[32*i +: 32] = bus.msg_block[511-32*i -: 32];
        end
    end

    // Recurrence for the word at w_index; indices stay in range because t >= 16
    always_comb begin
        idx_m2   = w_index - IW'(2);
        idx_m7   = w_index - IW'(7);
        idx_m15  = w_index - IW'(15);
        idx_m16  = w_index - IW'(16);
        w_m2     = w_vector[{idx_m2,  5'd0} +: 32];
        w_m7     = w_vector[{idx_m7,  5'd0} +: 32];
        w_m15    = w_vector[{idx_m15, 5'd0} +: 32];
        w_m16    = w_vector[{idx_m16, 5'd0} +: 32];
        new_word = sig1(w_m2) + w_m7 + sig0(w_m15) + w_m16;
    end

    // Control FSM; every output is registered alongside the state
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            w_vector   <= '0;
            w_index    <= '0;
            busy       <= 1'b0;
            w_complete <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        w_vector   <= load_vector;
                        w_index    <= IW'(16);
                        busy       <= 1'b1;
                        w_complete <= 1'b0;
                        state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    w_vector[{w_index, 5'd0} +: 32] <= new_word;
                    if (w_index == IW'(WK_LENGTH - 1)) begin
                        w_index    <= '0;
                        busy       <= 1'b0;
                        w_complete <= 1'b1;
                        state      <= DONE;
                    end else begin
                        w_index <= w_index + IW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.w_vector   = w_vector;
    assign bus.w_index    = w_index;
    assign bus.busy       = busy;
    assign bus.w_complete = w_complete;
endmodule

// File: tb/tb_sha256_w_schedule.sv
// tb/tb_sha256_w_schedule.sv - directed vector bench for sha256_w_schedule
module tb_sha256_w_schedule;
    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    sha256_w_schedule_if #(.WK_LENGTH(64)) bus ();

    sha256_w_schedule #(.WK_LENGTH(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        int          blk_id;
        bit          repulse;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t         vecs [13];
    logic [511:0] blocks [4];
    logic [511:0] abc_blk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [2047:0] model(input logic [511:0] m);
        logic [31:0]   w [64];
        logic [2047:0] r;
        logic [31:0]   s0;
        logic [31:0]   s1;
        for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int t = 0; t < 64; t++) r[32*t +: 32] = w[t];
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Start a block in the current cycle and follow it to completion
    task automatic run_block(input logic [511:0] blk, input bit repulse, input string tag);
        logic [2047:0] exp;
        int edges;
        int busy_cnt;
        exp = model(blk);
        bus.msg_block = blk;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        chk({tag, " load busy"}, 32'(bus.busy), 32'd1);
        chk({tag, " load w_complete"}, 32'(bus.w_complete), 32'd0);
        chk({tag, " load w_index"}, 32'(bus.w_index), 32'd16);
        chk({tag, " load upper cleared"}, 32'(bus.w_vector[2047:512] == '0), 32'd1);
        edges    = 1;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.w_complete && edges < 60) begin
            if (repulse && (edges % 5 == 0)) begin
                bus.start     = 1'b1;
                bus.msg_block = {16{$urandom}};
            end
            step();
            bus.start = 1'b0;
            edges++;
            if (bus.busy) busy_cnt++;
        end
        chk({tag, " completion edge"}, 32'(edges), 32'd49);
        chk({tag, " busy cycles"}, 32'(busy_cnt), 32'd48);
        chk({tag, " done w_index"}, 32'(bus.w_index), 32'd0);
        for (int t = 0; t < 64; t++) begin
            chk($sformatf("%s W%0d", tag, t), bus.w_vector[32*t +: 32], exp[32*t +: 32]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cur;
        int k;
        logic [31:0] w63_hold;

        abc_blk   = {32'h61626380, 448'h0, 32'h00000018};
        blocks[0] = abc_blk;
        blocks[1] = '0;
        blocks[2] = {512{1'b1}};
        for (int i = 0; i < 16; i++) blocks[3][32*i +: 32] = $urandom;

        vecs[0]  = '{"abc W0",   0, 1'b0, 0,  32'h61626380};
        vecs[1]  = '{"abc W15",  0, 1'b0, 15, 32'h00000018};
        vecs[2]  = '{"abc W16",  0, 1'b0, 16, 32'h61626380};
        vecs[3]  = '{"abc W17",  0, 1'b0, 17, 32'h000F0000};
        vecs[4]  = '{"abc W18",  0, 1'b0, 18, 32'h7DA86405};
        vecs[5]  = '{"abc W63",  0, 1'b0, 63, 32'h12B1EDEB};
        vecs[6]  = '{"zero W0",  1, 1'b0, 0,  32'h00000000};
        vecs[7]  = '{"zero W40", 1, 1'b0, 40, 32'h00000000};
        vecs[8]  = '{"zero W63", 1, 1'b0, 63, 32'h00000000};
        vecs[9]  = '{"ones W0",  2, 1'b1, 0,  32'hFFFFFFFF};
        vecs[10] = '{"ones W16", 2, 1'b1, 16, 32'h203FFFFC};
        vecs[11] = '{"ones W17", 2, 1'b1, 17, 32'h203FFFFC};
        vecs[12] = '{"rand W0",  3, 1'b1, 0,  blocks[3][511:480]};

        bus.start     = 1'b0;
        bus.msg_block = '0;
        reset         = 1'b1;
        step();
        step();
        reset = 1'b0;

        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("idle%0d w_index", c), 32'(bus.w_index), 32'd0);
            chk($sformatf("idle%0d busy", c), 32'(bus.busy), 32'd0);
            chk($sformatf("idle%0d w_complete", c), 32'(bus.w_complete), 32'd0);
            chk($sformatf("idle%0d w_vector zero", c), 32'(bus.w_vector == '0), 32'd1);
        end

        // Runs follow each other back-to-back: each new start is driven in the
        // same cycle the previous completion is observed
        cur = -1;
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].blk_id != cur) begin
                cur = vecs[i].blk_id;
                run_block(blocks[cur], vecs[i].repulse, $sformatf("blk%0d", cur));
            end
            chk(vecs[i].name, bus.w_vector[32*vecs[i].idx +: 32], vecs[i].exp);
        end

        // DONE holds the schedule while start stays low
        w63_hold = bus.w_vector[2047:2016];
        for (int c = 0; c < 3; c++) step();
        chk("done hold w_complete", 32'(bus.w_complete), 32'd1);
        chk("done hold busy", 32'(bus.busy), 32'd0);
        chk("done hold W63", bus.w_vector[2047:2016], w63_hold);

        // Reset in the middle of EXPAND
        bus.msg_block = abc_blk;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        k = 0;
        while (bus.w_index != 6'd30 && k < 40) begin
            step();
            k++;
        end
        chk("reached w_index 30", 32'(bus.w_index), 32'd30);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset w_index", 32'(bus.w_index), 32'd0);
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset w_complete", 32'(bus.w_complete), 32'd0);
        chk("midreset w_vector zero", 32'(bus.w_vector == '0), 32'd1);
        step();
        chk("midreset idle busy", 32'(bus.busy), 32'd0);

        run_block(abc_blk, 1'b0, "abc after reset");
        chk("abc after reset W18", bus.w_vector[32*18 +: 32], 32'h7DA86405);
        chk("abc after reset W63", bus.w_vector[32*63 +: 32], 32'h12B1EDEB);

        // Back-to-back from DONE into a different block: nothing may carry over
        run_block(blocks[1], 1'b0, "zero after abc");
        chk("zero after abc W63", bus.w_vector[32*63 +: 32], 32'h00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
